// File: rtl/md_sched.sv
// Multiply/divide sequencer beside the E-stage ALU: holds HI/LO and models a fixed mul/div latency.
// Optional feature: define MD_CANCEL_EN to add a cancel input that aborts an issuing or in-flight op.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_E,
  input  logic [2:0]  md_op_E,
  input  logic [31:0] src_a_E,
  input  logic [31:0] src_b_E,
  input  logic        md_use_D,
`ifdef MD_CANCEL_EN
  input  logic        cancel,
`endif
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  logic [0:0]  state;
  logic [3:0]  cnt;
  logic [63:0] stage;
  logic        stage_wr;

  logic        is_mul, is_div, is_muldiv, cancel_now, issue;
  logic [63:0] prod_u, prod_s, result;
  logic [31:0] mag_a, mag_b, den_u, den_s;
  logic [31:0] uq, ur, sq, sr;

`ifdef MD_CANCEL_EN
  assign cancel_now = cancel;
`else
  assign cancel_now = 1'b0;
`endif

  assign is_mul    = (md_op_E == OP_MULT) || (md_op_E == OP_MULTU);
  assign is_div    = (md_op_E == OP_DIV)  || (md_op_E == OP_DIVU);
  assign is_muldiv = is_mul || is_div;
  assign issue     = (state == IDLE) && start_E && is_muldiv && !cancel_now;

  assign busy     = (state == BUSY) || (start_E && is_muldiv && !cancel_now);
  assign stall_md = md_use_D && busy;

  // Signed division works on magnitudes so that MIN/-1 wraps instead of overflowing;
  // a zero divisor is replaced by 1 only to keep the datapath defined, the result is discarded.
  always_comb begin
    prod_u = {32'b0, src_a_E} * {32'b0, src_b_E};
    prod_s = {{32{src_a_E[31]}}, src_a_E} * {{32{src_b_E[31]}}, src_b_E};
    mag_a  = src_a_E[31] ? (32'd0 - src_a_E) : src_a_E;
    mag_b  = src_b_E[31] ? (32'd0 - src_b_E) : src_b_E;
    den_u  = (src_b_E == 32'd0) ? 32'd1 : src_b_E;
    den_s  = (mag_b == 32'd0) ? 32'd1 : mag_b;
    uq     = src_a_E / den_u;
    ur     = src_a_E % den_u;
    sq     = mag_a / den_s;
    sr     = mag_a % den_s;
    if (src_a_E[31] ^ src_b_E[31]) sq = 32'd0 - sq;
    if (src_a_E[31]) sr = 32'd0 - sr;
    case (md_op_E)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_DIV:   result = {sr, sq};
      OP_DIVU:  result = {ur, uq};
      default:  result = 64'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      stage    <= 64'd0;
      stage_wr <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            stage    <= result;
            stage_wr <= !(is_div && (src_b_E == 32'd0));
            cnt      <= is_div ? DIV_LOAD : MULT_LOAD;
            state    <= BUSY;
          end else if (start_E && (md_op_E == OP_MTHI)) begin
            hi <= src_a_E;
          end else if (start_E && (md_op_E == OP_MTLO)) begin
            lo <= src_a_E;
          end
        end
        default: begin
          if (cancel_now) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              state <= IDLE;
              if (stage_wr) {hi, lo} <= stage;
            end
          end
        end
      endcase
    end
  end

endmodule
